// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/execute controller for the program counter
module pc_sequencer #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [2:0]           o_pc_op,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  input  logic                 i_imem_rsp_valid,
  input  logic                 i_imem_rsp_err,
  input  logic [XLEN-1:0]      i_imem_rsp_data,
  output logic                 o_instr_valid,
  output logic [XLEN-1:0]      o_instr,
  input  logic                 i_instr_ready,
  input  logic                 i_exec_done,
  input  logic [1:0]           i_exec_kind,
  input  logic                 i_br_taken,
  input  logic                 i_halt_req,
  input  logic                 i_resume,
  output logic                 o_halted,
  output logic                 o_fault,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] PC_STOP   = 3'd0;
  localparam logic [2:0] PC_INCR   = 3'd1;
  localparam logic [2:0] PC_JAL    = 3'd2;
  localparam logic [2:0] PC_JALR   = 3'd3;
  localparam logic [2:0] PC_BRANCH = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t                 state, next_state;
  logic [CW-1:0]          wait_cnt;
  logic [XLEN-1:0]        instr_q;
  logic [INSTRET_W-1:0]   instret_q;
  logic [2:0]             pc_op_c;
  logic                   retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state <= next_state;
      // Counter runs only while waiting, so it is zero on every entry to WAIT.
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
      if (state == S_WAIT && i_imem_rsp_valid && !i_imem_rsp_err)
        instr_q <= i_imem_rsp_data;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    pc_op_c    = PC_STOP;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (i_imem_req_ready) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rsp_valid)       next_state = i_imem_rsp_err ? S_FAULT : S_ISSUE;
        else if (wait_cnt == TO_LAST) next_state = S_FAULT;
      end
      S_ISSUE: begin
        if (i_instr_ready) next_state = S_EXEC;
      end
      S_EXEC: begin
        if (i_exec_done) begin
          retire = 1'b1;
          case (i_exec_kind)
            2'd0:    pc_op_c = PC_INCR;
            2'd1:    pc_op_c = PC_JAL;
            2'd2:    pc_op_c = PC_JALR;
            default: pc_op_c = i_br_taken ? PC_BRANCH : PC_INCR;
          endcase
          next_state = i_halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (i_resume && !i_halt_req) next_state = S_FETCH;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FETCH;
    endcase
  end

  // Gate the two combinational-looking outputs so nothing leaks while rst is held.
  assign o_pc_op          = rst ? PC_STOP : pc_op_c;
  assign o_imem_req_valid = (state == S_FETCH) && !rst;
  assign o_instr_valid    = (state == S_ISSUE);
  assign o_instr          = instr_q;
  assign o_halted         = (state == S_HALT);
  assign o_fault          = (state == S_FAULT);
  assign o_instret        = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;
  localparam int XLEN = 32;
  localparam int IW   = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      o_pc_op;
  logic            o_imem_req_valid;
  logic            i_imem_req_ready;
  logic            i_imem_rsp_valid;
  logic            i_imem_rsp_err;
  logic [XLEN-1:0] i_imem_rsp_data;
  logic            o_instr_valid;
  logic [XLEN-1:0] o_instr;
  logic            i_instr_ready;
  logic            i_exec_done;
  logic [1:0]      i_exec_kind;
  logic            i_br_taken;
  logic            i_halt_req;
  logic            i_resume;
  logic            o_halted;
  logic            o_fault;
  logic [IW-1:0]   o_instret;

  int            errors = 0;
  int            checks = 0;
  logic [IW-1:0] exp_instret;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(XLEN), .INSTRET_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .o_pc_op(o_pc_op),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_err(i_imem_rsp_err),
    .i_imem_rsp_data(i_imem_rsp_data), .o_instr_valid(o_instr_valid),
    .o_instr(o_instr), .i_instr_ready(i_instr_ready), .i_exec_done(i_exec_done),
    .i_exec_kind(i_exec_kind), .i_br_taken(i_br_taken), .i_halt_req(i_halt_req),
    .i_resume(i_resume), .o_halted(o_halted), .o_fault(o_fault), .o_instret(o_instret)
  );

  // Architectural rule: which PC update a completed instruction produces.
  function automatic logic [2:0] model_op(input logic [1:0] kind, input logic taken);
    if (kind == 2'd0) return 3'd1;
    if (kind == 2'd1) return 3'd2;
    if (kind == 2'd2) return 3'd3;
    return taken ? 3'd4 : 3'd1;
  endfunction

  task automatic idle();
    rst = 1'b0; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_err = 1'b0;
    i_imem_rsp_data = '0; i_instr_ready = 1'b0; i_exec_done = 1'b0; i_exec_kind = 2'd0;
    i_br_taken = 1'b0; i_halt_req = 1'b0; i_resume = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); rst = 1'b1;
      i_exec_done = 1'b1; i_exec_kind = 2'd1; i_imem_req_ready = 1'b1;
      #1;
      if (i == 1) begin
        checks++;
        if (o_pc_op !== 3'd0 || o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0 ||
            o_instr !== '0 || o_halted !== 1'b0 || o_fault !== 1'b0 || o_instret !== '0) begin
          errors++;
          $display("FAIL reset_values: pc_op=%0d req=%b ival=%b instr=%h halted=%b fault=%b instret=%0d, want all 0",
                   o_pc_op, o_imem_req_valid, o_instr_valid, o_instr, o_halted, o_fault, o_instret);
        end
      end
    end
    exp_instret = '0;
  endtask

  // One full instruction; delays count the extra cycles before each handshake fires.
  task automatic do_instr(input logic [1:0] kind, input logic taken, input logic halt,
                          input int d_req, input int d_rsp, input int d_dec, input int d_done,
                          input logic noise);
    logic [XLEN-1:0] data;
    logic [2:0]      want;
    data = $urandom();
    for (int i = 0; i <= d_req; i++) begin
      @(negedge clk); idle();
      if (noise) begin
        i_exec_done = 1'($urandom); i_exec_kind = 2'($urandom); i_br_taken = 1'($urandom);
        i_resume = 1'($urandom); i_halt_req = 1'($urandom);
        i_imem_rsp_valid = 1'($urandom); i_imem_rsp_err = 1'($urandom); i_imem_rsp_data = $urandom();
      end
      i_imem_req_ready = (i == d_req);
      #1; checks++;
      if (o_imem_req_valid !== 1'b1 || o_pc_op !== 3'd0 || o_instr_valid !== 1'b0 ||
          o_halted !== 1'b0 || o_fault !== 1'b0 || o_instret !== exp_instret) begin
        errors++;
        $display("FAIL fetch: req=%b pc_op=%0d ival=%b halted=%b fault=%b instret=%0d, want 1 0 0 0 0 %0d",
                 o_imem_req_valid, o_pc_op, o_instr_valid, o_halted, o_fault, o_instret, exp_instret);
      end
    end
    for (int i = 0; i <= d_rsp; i++) begin
      @(negedge clk); idle();
      if (noise) begin
        i_exec_done = 1'($urandom); i_exec_kind = 2'($urandom); i_resume = 1'($urandom);
        i_halt_req = 1'($urandom); i_imem_req_ready = 1'($urandom);
      end
      i_imem_rsp_data = $urandom();
      if (i == d_rsp) begin i_imem_rsp_valid = 1'b1; i_imem_rsp_data = data; end
      #1; checks++;
      if (o_imem_req_valid !== 1'b0 || o_pc_op !== 3'd0 || o_instr_valid !== 1'b0 ||
          o_fault !== 1'b0 || o_instret !== exp_instret) begin
        errors++;
        $display("FAIL wait: req=%b pc_op=%0d ival=%b fault=%b instret=%0d, want 0 0 0 0 %0d",
                 o_imem_req_valid, o_pc_op, o_instr_valid, o_fault, o_instret, exp_instret);
      end
    end
    for (int i = 0; i <= d_dec; i++) begin
      @(negedge clk); idle();
      if (noise) begin
        i_exec_done = 1'($urandom); i_exec_kind = 2'($urandom); i_resume = 1'($urandom);
        i_halt_req = 1'($urandom);
      end
      i_instr_ready = (i == d_dec);
      #1; checks++;
      if (o_instr_valid !== 1'b1 || o_instr !== data || o_pc_op !== 3'd0 ||
          o_imem_req_valid !== 1'b0 || o_instret !== exp_instret) begin
        errors++;
        $display("FAIL issue: ival=%b instr=%h pc_op=%0d req=%b instret=%0d, want 1 %h 0 0 %0d",
                 o_instr_valid, o_instr, o_pc_op, o_imem_req_valid, o_instret, data, exp_instret);
      end
    end
    for (int i = 0; i <= d_done; i++) begin
      @(negedge clk); idle();
      if (i < d_done) begin
        if (noise) begin
          i_halt_req = 1'($urandom); i_resume = 1'($urandom);
          i_exec_kind = 2'($urandom); i_br_taken = 1'($urandom);
        end
        want = 3'd0;
      end else begin
        i_exec_done = 1'b1; i_exec_kind = kind; i_halt_req = halt;
        i_br_taken = (kind == 2'd3 || !noise) ? taken : 1'($urandom);
        want = model_op(kind, taken);
      end
      #1; checks++;
      if (o_pc_op !== want || o_instr_valid !== 1'b0 || o_imem_req_valid !== 1'b0 ||
          o_instret !== exp_instret) begin
        errors++;
        $display("FAIL exec: pc_op=%0d ival=%b req=%b instret=%0d, want %0d 0 0 %0d",
                 o_pc_op, o_instr_valid, o_imem_req_valid, o_instret, want, exp_instret);
      end
    end
    exp_instret = exp_instret + 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); idle(); #1; checks++;
    if (o_imem_req_valid !== 1'b1 || o_pc_op !== 3'd0) begin
      errors++;
      $display("FAIL first_fetch: req=%b pc_op=%0d, want 1 0", o_imem_req_valid, o_pc_op);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int n = 0; n < 3; n++) do_instr(2'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    @(negedge clk); idle(); #1; checks++;
    if (o_instret !== 64'd3 || o_imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_stream: instret=%0d req=%b, want 3 1", o_instret, o_imem_req_valid);
    end
  endtask

  task automatic test_control_flow();
    do_instr(2'd1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    do_instr(2'd3, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    do_instr(2'd3, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_instr(2'd0, 1'b0, 1'b0, 5, 0, 3, 0, 1'b0);
    do_instr(2'd1, 1'b0, 1'b0, 2, 3, 1, 4, 1'b0);
  endtask

  task automatic test_halt();
    logic hr [4];
    logic rs [4];
    hr = '{1'b1, 1'b1, 1'b0, 1'b0};
    rs = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_instr(2'd0, 1'b0, 1'b1, 0, 1, 0, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      i_halt_req = hr[i]; i_resume = rs[i];
      i_exec_done = 1'b1; i_exec_kind = 2'($urandom); i_imem_rsp_valid = 1'b1;
      #1; checks++;
      if (o_halted !== 1'b1 || o_pc_op !== 3'd0 || o_imem_req_valid !== 1'b0 ||
          o_instret !== exp_instret) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b pc_op=%0d req=%b instret=%0d, want 1 0 0 %0d",
                 i, o_halted, o_pc_op, o_imem_req_valid, o_instret, exp_instret);
      end
    end
    do_instr(2'd2, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      do_instr(2'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 6), $urandom_range(0, TO - 1),
               $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
  endtask

  task automatic test_fault_err();
    @(negedge clk); idle(); i_imem_req_ready = 1'b1;
    @(negedge clk); idle(); i_imem_rsp_valid = 1'b1; i_imem_rsp_err = 1'b1; #1; checks++;
    if (o_fault !== 1'b0 || o_imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_wait: fault=%b req=%b, want 0 0", o_fault, o_imem_req_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); idle();
      i_imem_req_ready = 1'b1; i_exec_done = 1'b1; i_exec_kind = 2'($urandom);
      i_resume = 1'($urandom); i_imem_rsp_valid = 1'($urandom); i_instr_ready = 1'b1;
      #1; checks++;
      if (o_fault !== 1'b1 || o_imem_req_valid !== 1'b0 || o_pc_op !== 3'd0 ||
          o_instret !== exp_instret || o_halted !== 1'b0) begin
        errors++;
        $display("FAIL err_fault%0d: fault=%b req=%b pc_op=%0d instret=%0d halted=%b, want 1 0 0 %0d 0",
                 i, o_fault, o_imem_req_valid, o_pc_op, o_instret, exp_instret, o_halted);
      end
    end
    do_reset();
  endtask

  task automatic test_timeout();
    do_instr(2'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    @(negedge clk); idle(); i_imem_req_ready = 1'b1;
    for (int i = 0; i < TO + 3; i++) begin
      @(negedge clk); idle();
      if (i >= TO) begin i_imem_rsp_valid = 1'b1; i_imem_rsp_data = $urandom(); end
      #1; checks++;
      if (o_fault !== (i >= TO) || o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout%0d: fault=%b req=%b ival=%b, want %b 0 0",
                 i, o_fault, o_imem_req_valid, o_instr_valid, (i >= TO));
      end
    end
    do_reset();
    do_instr(2'd3, 1'b1, 1'b0, 1, 2, 1, 2, 1'b1);
  endtask

  initial begin
    idle();
    exp_instret = '0;
    test_reset();
    test_sequential();
    test_control_flow();
    test_backpressure();
    test_halt();
    test_random();
    test_fault_err();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute controller for the program counter register. It drives the PC opcode, runs the instruction-memory request/response handshake, and holds each fetched instruction for decode. It converts execute-stage completion (sequential, JAL, JALR, branch taken/not taken) into exactly one PC update per instruction. It also provides halt/resume, a fetch-timeout fault and a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, instruction/data width
- INSTRET_W, 64, width of retired-instruction counter
- TIMEOUT, 255, max cycles waiting for an imem response before fault (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- o_pc_op  out  3  PC opcode: PcStop=0, PcIncr=1, PcJAL=2, PcJALR=3, PcBranch=4 (5–7 never driven)
- o_imem_req_valid  out  1  fetch request at current PC
- i_imem_req_ready  in  1  imem accepts request
- i_imem_rsp_valid  in  1  fetch response valid
- i_imem_rsp_err  in  1  fetch response is a bus error
- i_imem_rsp_data  in  XLEN  fetched instruction
- o_instr_valid  out  1  held instruction offered to decode
- o_instr  out  XLEN  held instruction
- i_instr_ready  in  1  decode accepts instruction
- i_exec_done  in  1  instruction finished execute; kind below valid this cycle
- i_exec_kind  in  2  0=sequential, 1=JAL, 2=JALR, 3=branch
- i_br_taken  in  1  branch outcome, valid with i_exec_done and kind=3
- i_halt_req  in  1  level; halt at next instruction boundary
- i_resume  in  1  pulse; leave HALT
- o_halted  out  1  in HALT state
- o_fault  out  1  sticky fault (bus error or timeout)
- o_instret  out  INSTRET_W  retired-instruction count

## Operation
- States: FETCH, WAIT, ISSUE, EXEC, HALT, FAULT. Reset → FETCH.
- FETCH: o_imem_req_valid=1. On i_imem_req_ready → WAIT. Responses in FETCH are ignored.
- WAIT: timeout counter increments each cycle. On i_imem_rsp_valid:
  - if i_imem_rsp_err → FAULT;
  - else latch data into o_instr → ISSUE.
  - If the counter reaches TIMEOUT with no response → FAULT.
  - Counter clears on entry to WAIT.
- ISSUE: o_instr_valid=1 until i_instr_ready, then → EXEC. o_instr stays stable while valid.
- EXEC: wait for i_exec_done. In the done cycle, o_pc_op is:
  - kind 0 → PcIncr;
  - kind 1 → PcJAL;
  - kind 2 → PcJALR;
  - kind 3 with i_br_taken → PcBranch;
  - kind 3 with !i_br_taken → PcIncr.
  - Also in the done cycle, o_instret increments by 1 (wraps modulo 2^INSTRET_W).
  - Next state is HALT if i_halt_req=1 that cycle, else FETCH.
- HALT: o_halted=1. Exit to FETCH when i_resume=1 and i_halt_req=0. Otherwise stay.
- FAULT: o_fault=1. Absorbing until rst. No requests are issued; o_pc_op=PcStop.
- o_pc_op=PcStop in every cycle other than the EXEC done cycle. The PC changes exactly once per retired instruction.
- i_exec_done outside EXEC is ignored (no PC op, no count). i_halt_req is honoured only at the EXEC done boundary; a halt request in FETCH/WAIT/ISSUE lets the instruction complete first.
- i_resume outside HALT is ignored.

## Timing
- Reset values:
  - o_pc_op=PcStop, o_imem_req_valid=0 during rst;
  - o_instr_valid=0, o_instr=0, o_halted=0, o_fault=0, o_instret=0, state=FETCH.
- o_imem_req_valid asserts in the first cycle after rst deasserts. PC is 0 there, since the PC register resets with the same rst.
- All outputs are registered-state decodes. o_pc_op is combinational from state, i_exec_done, i_exec_kind and i_br_taken only, with no imem inputs in the path.
- PC register updates on the edge ending the done cycle. The following FETCH cycle therefore presents the new PC.
- Minimum instruction period is 4 cycles (FETCH, WAIT with response in its first cycle, ISSUE with ready, EXEC with done).
- Fault is flagged on the edge after the error response, or after TIMEOUT WAIT cycles.
- rst mid-operation (any state) returns to FETCH next cycle. A pending held instruction is discarded and o_instret is cleared.

## Test plan
- Sequential stream: ready/rsp/instr_ready/done each asserted in the earliest cycle, kind=0 ×3. Required:
  - o_pc_op=PcIncr exactly every 4th cycle;
  - o_instret=3;
  - o_imem_req_valid asserted in cycles 0, 4, 8 after reset.
- Control flow: done with kind=1, 2, 3+taken, 3+not-taken. Required: o_pc_op = 2, 3, 4, 1 respectively, each for one cycle only.
- Backpressure: i_imem_req_ready low 5 cycles, i_instr_ready low 3 cycles. Required: o_imem_req_valid held 6 cycles, o_instr stable for 4 cycles, no PC op before done.
- Halt/resume:
  - i_halt_req high at done → o_halted=1 next cycle, o_pc_op=PcStop while halted.
  - i_resume with halt_req=1 → remain halted.
  - i_resume with halt_req=0 → FETCH next cycle.
- Faults:
  - rsp_err=1 → o_fault=1 next cycle, with no further requests over 20 cycles.
  - With TIMEOUT=4 and no response → o_fault after 4 WAIT cycles.
  - rst → o_fault=0 and o_instret=0.
- Spurious inputs: i_exec_done pulses in FETCH/WAIT/ISSUE and i_resume outside HALT. Required: o_pc_op stays PcStop and o_instret is unchanged.
